pong_game_core: RTL and testbench

- Parametrised single-clock successor to the 2 Hz ping-pong FSM path.
- Replaces the divided slow clock with an internal tick-enable, so all state runs on Clk.
- Generalises LED count, score width and tick period; adds progressive ball speed-up, hit/miss detection, a saturating score and a best-score register.
- Inputs are the debounced, Clk-synchronous single-cycle button pulses; win_counter feeds the existing BCD/7-segment path.

---
 rtl/pong_game_core.sv | 198 +++++++++++++++++++
 tb/tb_pong_game_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_core.sv
// pong_game_core
// Single-clock ping-pong game core. A tick enable derived from Clk moves a
// one-hot ball along N_LEDS lamps; each successful return shortens the step
// period down to MIN_DIV. Score saturates, best score survives soft resets.
//
// Ports
//   Clk            system clock
//   Rst            asynchronous active-low reset
//   begin_pulse    one-cycle start request (IDLE/LOSE only)
//   play_pulse     one-cycle player hit
//   reset_pulse    one-cycle soft reset, keeps best_score
//   LEDs           one-hot ball position, all ones in LOSE, zero in IDLE
//   Coloured_leds  {red, green, blue}: 001 idle, 010 playing, 100 lost
//   win_counter    current score
//   best_score     highest score since Rst
//   lose           high while in LOSE
//   hit_pulse      one-cycle strobe per scored hit
//
// state  | meaning
// S_IDLE | waiting for begin_pulse, lamps dark
// S_OUT  | ball travelling toward the player (pos rising)
// S_BACK | ball returning after a hit (pos falling), presses ignored
// S_LOSE | game over, score frozen until begin_pulse
module pong_game_core #(
  parameter int N_LEDS       = 4,
  parameter int SCORE_W      = 4,
  parameter int TICK_DIV     = 50_000_000,
  parameter int MIN_DIV      = 12_500_000,
  parameter int SPEEDUP_STEP = 2_500_000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               begin_pulse,
  input  logic               play_pulse,
  input  logic               reset_pulse,
  output logic [N_LEDS-1:0]  LEDs,
  output logic [2:0]         Coloured_leds,
  output logic [SCORE_W-1:0] win_counter,
  output logic [SCORE_W-1:0] best_score,
  output logic               lose,
  output logic               hit_pulse
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam int DIV_W = $clog2(TICK_DIV + 1);

  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [DIV_W-1:0]   DIV_INIT  = DIV_W'(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]   DIV_STEP  = DIV_W'(SPEEDUP_STEP);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [N_LEDS-1:0]  LED_ONE   = N_LEDS'(1);
  // Compared at 33 bits so MIN_DIV + SPEEDUP_STEP can never wrap.
  localparam logic [32:0]        DIV_FLOOR = 33'(MIN_DIV) + 33'(SPEEDUP_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_BACK = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   cur_div_q, cur_div_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic [2:0]         col_q, col_d;
  logic               lose_q, lose_d;
  logic               hit_q, hit_d;

  logic               running;
  logic               tick;
  logic [DIV_W-1:0]   div_fast;
  logic [SCORE_W-1:0] best_upd;

  assign running  = (state_q == S_OUT) || (state_q == S_BACK);
  assign tick     = running && (cnt_q == cur_div_q - DIV_W'(1));
  // Subtract only when the result stays at or above MIN_DIV; else clamp.
  assign div_fast = (33'(cur_div_q) > DIV_FLOOR) ? cur_div_q - DIV_STEP : DIV_MIN;
  assign best_upd = (score_q > best_q) ? score_q : best_q;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cur_div_d = cur_div_q;
    score_d   = score_q;
    best_d    = best_q;
    hit_d     = 1'b0;
    cnt_d     = running ? (tick ? '0 : cnt_q + DIV_W'(1)) : '0;

    if (reset_pulse) begin
      state_d   = S_IDLE;
      pos_d     = '0;
      score_d   = '0;
      cur_div_d = DIV_INIT;
    end else begin
      case (state_q)
        S_IDLE, S_LOSE: begin
          if (begin_pulse) begin
            state_d   = S_OUT;
            pos_d     = '0;
            score_d   = '0;
            cur_div_d = DIV_INIT;
          end
        end
        S_OUT: begin
          // A press at the far end wins over a coincident tick.
          if (play_pulse) begin
            if (pos_q == POS_LAST) begin
              state_d   = S_BACK;
              pos_d     = POS_LAST - POS_W'(1);
              hit_d     = 1'b1;
              cur_div_d = div_fast;
              if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
            end else begin
              state_d = S_LOSE;
              best_d  = best_upd;
            end
          end else if (tick) begin
            if (pos_q == POS_LAST) begin
              state_d = S_LOSE;
              best_d  = best_upd;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
        end
        S_BACK: begin
          if (tick) begin
            if (pos_q == '0) begin
              state_d = S_OUT;
              pos_d   = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Every state entry restarts the step period.
    if (state_d != state_q) cnt_d = '0;

    leds_d = '0;
    col_d  = 3'b001;
    lose_d = 1'b0;
    case (state_d)
      S_OUT, S_BACK: begin
        leds_d = LED_ONE << pos_d;
        col_d  = 3'b010;
      end
      S_LOSE: begin
        leds_d = '1;
        col_d  = 3'b100;
        lose_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      cnt_q     <= '0;
      cur_div_q <= DIV_INIT;
      score_q   <= '0;
      best_q    <= '0;
      leds_q    <= '0;
      col_q     <= 3'b001;
      lose_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      score_q   <= score_d;
      best_q    <= best_d;
      leds_q    <= leds_d;
      col_q     <= col_d;
      lose_q    <= lose_d;
      hit_q     <= hit_d;
    end
  end

  assign LEDs          = leds_q;
  assign Coloured_leds = col_q;
  assign win_counter   = score_q;
  assign best_score    = best_q;
  assign lose          = lose_q;
  assign hit_pulse     = hit_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Testbench for pong_game_core with N_LEDS=4, SCORE_W=4, TICK_DIV=4,
// MIN_DIV=2, SPEEDUP_STEP=1. Expected output snapshots are queued as stimulus
// is issued; a monitor thread pops one entry every time the registered output
// tuple changes and checks both the values and the cycle gap since the
// previous change (gap 0 means the gap is not checked).
module tb_pong_game_core;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       begin_pulse = 1'b0;
  logic       play_pulse = 1'b0;
  logic       reset_pulse = 1'b0;
  logic [3:0] LEDs;
  logic [2:0] Coloured_leds;
  logic [3:0] win_counter;
  logic [3:0] best_score;
  logic       lose;
  logic       hit_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] leds;
    logic [2:0] col;
    logic [3:0] score;
    logic [3:0] best;
    logic       lose;
    logic       hit;
    int         gap;
  } exp_t;

  exp_t sb_q[$];

  pong_game_core #(
    .N_LEDS(4), .SCORE_W(4), .TICK_DIV(4), .MIN_DIV(2), .SPEEDUP_STEP(1)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .begin_pulse(begin_pulse), .play_pulse(play_pulse), .reset_pulse(reset_pulse),
    .LEDs(LEDs), .Coloured_leds(Coloured_leds),
    .win_counter(win_counter), .best_score(best_score),
    .lose(lose), .hit_pulse(hit_pulse)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string name, input logic [3:0] leds, input logic [2:0] col,
                      input logic [3:0] score, input logic [3:0] best,
                      input logic lz, input logic hit, input int gap);
    exp_t e;
    e.name = name; e.leds = leds; e.col = col; e.score = score;
    e.best = best; e.lose = lz; e.hit = hit; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Playing-state snapshot: green, not lost, no hit strobe.
  task automatic pp(input string name, input logic [3:0] leds, input logic [3:0] score,
                    input logic [3:0] best, input int gap);
    push(name, leds, 3'b010, score, best, 1'b0, 1'b0, gap);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic monitor();
    logic [16:0] snap, prev;
    int cyc, last_cyc;
    bit primed;
    exp_t e;
    primed = 1'b0; cyc = 0; last_cyc = 0; prev = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      snap = {LEDs, Coloured_leds, win_counter, best_score, lose, hit_pulse};
      if (!primed) begin
        primed = 1'b1;
        prev = snap;
        last_cyc = cyc;
      end else if (snap !== prev) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got LEDs=%b rgb=%b score=%0d best=%0d lose=%b hit=%b, none required",
                   LEDs, Coloured_leds, win_counter, best_score, lose, hit_pulse);
        end else begin
          e = sb_q.pop_front();
          if (snap !== {e.leds, e.col, e.score, e.best, e.lose, e.hit}) begin
            n_fail++;
            $display("FAIL %s: got LEDs=%b rgb=%b score=%0d best=%0d lose=%b hit=%b, required LEDs=%b rgb=%b score=%0d best=%0d lose=%b hit=%b",
                     e.name, LEDs, Coloured_leds, win_counter, best_score, lose, hit_pulse,
                     e.leds, e.col, e.score, e.best, e.lose, e.hit);
          end
          if (e.gap != 0) begin
            n_checks++;
            if (cyc - last_cyc != e.gap) begin
              n_fail++;
              $display("FAIL %s_gap: got %0d cycles required %0d", e.name, cyc - last_cyc, e.gap);
            end
          end
        end
        prev = snap;
        last_cyc = cyc;
      end
    end
  endtask

  // Caller is just after a rising edge; the pulse is sampled on the next one.
  task automatic press(input bit b, input bit p, input bit r);
    begin_pulse = b; play_pulse = p; reset_pulse = r;
    @(posedge Clk); #1;
    begin_pulse = 1'b0; play_pulse = 1'b0; reset_pulse = 1'b0;
  endtask

  task automatic wait_leds(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (LEDs !== v && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (LEDs !== v) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: LEDs=%b required %b", name, LEDs, v);
    end
  endtask

  // Serve from IDLE/LOSE with the initial period of 4 and run to the far end.
  task automatic start_game(input logic [3:0] best);
    pp("serve", 4'b0001, 4'd0, best, 0);
    pp("out_p1", 4'b0010, 4'd0, best, 4);
    pp("out_p2", 4'b0100, 4'd0, best, 4);
    pp("out_p3", 4'b1000, 4'd0, best, 4);
    press(1'b1, 1'b0, 1'b0);
    wait_leds(4'b1000, "serve");
  endtask

  // Called with the ball just arrived at the far end. Presses after 'delay'
  // cycles, then follows the return and bounce with the new period d.
  task automatic hit(input logic [3:0] sc, input logic [3:0] best, input int d,
                     input int delay, input bit extra);
    push("hit", 4'b0100, 3'b010, sc, best, 1'b0, 1'b1, delay + 1);
    pp("hit_end", 4'b0100, sc, best, 1);
    pp("back_p1", 4'b0010, sc, best, d - 1);
    pp("back_p0", 4'b0001, sc, best, d);
    pp("bounce_p1", 4'b0010, sc, best, d);
    pp("out_p2", 4'b0100, sc, best, d);
    pp("out_p3", 4'b1000, sc, best, d);
    repeat (delay) begin @(posedge Clk); #1; end
    press(1'b0, 1'b1, 1'b0);
    if (extra) press(1'b0, 1'b1, 1'b0);
    wait_leds(4'b1000, "hit_return");
  endtask

  initial begin
    fork
      monitor();
    join_none

    #2 Rst = 1'b0;
    #1;
    chk("rst_leds", 32'(LEDs), 32'h0);
    chk("rst_rgb", 32'(Coloured_leds), 32'h1);
    chk("rst_score", 32'(win_counter), 32'h0);
    chk("rst_best", 32'(best_score), 32'h0);
    chk("rst_lose", 32'(lose), 32'h0);
    chk("rst_hit", 32'(hit_pulse), 32'h0);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;

    // Serve, first hit, period shrinking 4 -> 3 -> 2 -> 2, then a miss.
    start_game(4'd0);
    hit(4'd1, 4'd0, 3, 0, 1'b0);
    hit(4'd2, 4'd0, 2, 0, 1'b0);
    hit(4'd3, 4'd0, 2, 0, 1'b0);
    push("miss_lose", 4'b1111, 3'b100, 4'd3, 4'd3, 1'b1, 1'b0, 2);
    wait_leds(4'b1111, "miss");

    // Early swing at pos 1.
    pp("serve_early", 4'b0001, 4'd0, 4'd3, 0);
    pp("early_p1", 4'b0010, 4'd0, 4'd3, 4);
    press(1'b1, 1'b0, 1'b0);
    wait_leds(4'b0010, "early_p1");
    push("early_lose", 4'b1111, 3'b100, 4'd0, 4'd3, 1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 1'b0);
    wait_leds(4'b1111, "early");

    // Press during BACK ignored; then press on the tick cycle at the far end.
    start_game(4'd3);
    hit(4'd1, 4'd3, 3, 0, 1'b1);
    hit(4'd2, 4'd3, 2, 2, 1'b0);

    // Drive the score into saturation.
    for (int s = 3; s <= 17; s++)
      hit((s > 15) ? 4'd15 : 4'(s), 4'd3, 2, 0, 1'b0);

    // Soft reset keeps best (3: best only updates on entering LOSE).
    push("soft_reset", 4'b0000, 3'b001, 4'd0, 4'd3, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b1);
    wait_leds(4'b0000, "soft_reset");

    start_game(4'd3);
    push("reset_beats_play", 4'b0000, 3'b001, 4'd0, 4'd3, 1'b0, 1'b0, 1);
    press(1'b0, 1'b1, 1'b1);
    wait_leds(4'b0000, "reset_beats_play");

    // Lower score does not replace best; begin from LOSE restores period 4.
    start_game(4'd3);
    hit(4'd1, 4'd3, 3, 0, 1'b0);
    push("low_lose", 4'b1111, 3'b100, 4'd1, 4'd3, 1'b1, 1'b0, 3);
    wait_leds(4'b1111, "low_lose");
    pp("serve_lose", 4'b0001, 4'd0, 4'd3, 0);
    pp("relaunch_p1", 4'b0010, 4'd0, 4'd3, 4);
    pp("relaunch_p2", 4'b0100, 4'd0, 4'd3, 4);
    press(1'b1, 1'b0, 1'b0);
    wait_leds(4'b0100, "relaunch");

    // Hard reset mid-game at pos 2 acts immediately.
    push("hard_reset", 4'b0000, 3'b001, 4'd0, 4'd0, 1'b0, 1'b0, 0);
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    chk("async_leds", 32'(LEDs), 32'h0);
    chk("async_score", 32'(win_counter), 32'h0);
    chk("async_best", 32'(best_score), 32'h0);
    chk("async_rgb", 32'(Coloured_leds), 32'h1);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    repeat (3) begin @(posedge Clk); #1; end
    pp("serve_after_rst", 4'b0001, 4'd0, 4'd0, 0);
    pp("after_rst_p1", 4'b0010, 4'd0, 4'd0, 4);
    press(1'b1, 1'b0, 1'b0);
    wait_leds(4'b0010, "after_rst");

    @(negedge Clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
